// File: rtl/fifo_frame_writer.sv
// Write-side framer in front of the async FIFO: header (sequence), payload, XOR checksum.
// Throttles on the FIFO full flag and truncates frames longer than MAX_LEN.
module fifo_frame_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 64
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0] fifo_wdata_o,
    output logic [DATA_WIDTH-1:0] seq_o,
    output logic [15:0]           frame_cnt_o,
    output logic                  trunc_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   seq_q, seq_d;
    logic [DATA_WIDTH-1:0]   csum_q, csum_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    trunc_pend_q, trunc_pend_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic                    trunc_q, trunc_d;

    logic wr_ok;
    logic accept;

    assign wr_ok  = ~fifo_full_i;
    assign accept = s_valid_i & s_ready_o;

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            seq_q        <= '0;
            csum_q       <= '0;
            cnt_q        <= '0;
            trunc_pend_q <= 1'b0;
            frame_cnt_q  <= '0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            csum_q       <= csum_d;
            cnt_q        <= cnt_d;
            trunc_pend_q <= trunc_pend_d;
            frame_cnt_q  <= frame_cnt_d;
            trunc_q      <= trunc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        csum_d       = csum_q;
        cnt_d        = cnt_q;
        trunc_pend_d = trunc_pend_q;
        frame_cnt_d  = frame_cnt_q;
        trunc_d      = 1'b0;
        s_ready_o    = 1'b0;
        fifo_wr_en_o = 1'b0;
        fifo_wdata_o = '0;

        case (state_q)
            // Wait for a word to show up; it is consumed later, in DATA.
            IDLE: begin
                if (s_valid_i) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                fifo_wr_en_o = wr_ok;
                fifo_wdata_o = wr_ok ? seq_q : '0;
                if (wr_ok) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                s_ready_o    = wr_ok;
                fifo_wr_en_o = s_valid_i & wr_ok;
                fifo_wdata_o = (s_valid_i & wr_ok) ? s_data_i : '0;
                if (accept) begin
                    csum_d = csum_q ^ s_data_i;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (s_last_i) begin
                        state_d = CSUM;
                    end else if (cnt_q == CNT_W'(MAX_LEN - 1)) begin
                        // Frame hit the length cap; the rest is discarded in DROP.
                        state_d      = CSUM;
                        trunc_pend_d = 1'b1;
                    end
                end
            end
            CSUM: begin
                fifo_wr_en_o = wr_ok;
                fifo_wdata_o = wr_ok ? csum_q : '0;
                if (wr_ok) begin
                    seq_d        = seq_q + DATA_WIDTH'(1);
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    csum_d       = '0;
                    cnt_d        = '0;
                    trunc_d      = trunc_pend_q;
                    trunc_pend_d = 1'b0;
                    state_d      = trunc_pend_q ? DROP : IDLE;
                end
            end
            DROP: begin
                // Drain the tail of a truncated frame without touching the FIFO.
                s_ready_o = 1'b1;
                if (s_valid_i && s_last_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign seq_o       = seq_q;
    assign frame_cnt_o = frame_cnt_q;
    assign trunc_o     = trunc_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Bench for fifo_frame_writer (MAX_LEN=4): frame-level reference model feeds a write scoreboard.
module tb_fifo_frame_writer;

    localparam int DW  = 8;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready_o;
    logic          fifo_full;
    logic          fifo_wr_en_o;
    logic [DW-1:0] fifo_wdata_o;
    logic [DW-1:0] seq_o;
    logic [15:0]   frame_cnt_o;
    logic          trunc_o;
    logic          busy_o;

    fifo_frame_writer #(.DATA_WIDTH(DW), .MAX_LEN(MAX)) dut (
        .wr_clk      (clk),
        .rst         (rst),
        .s_valid_i   (s_valid),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .s_ready_o   (s_ready_o),
        .fifo_full_i (fifo_full),
        .fifo_wr_en_o(fifo_wr_en_o),
        .fifo_wdata_o(fifo_wdata_o),
        .seq_o       (seq_o),
        .frame_cnt_o (frame_cnt_o),
        .trunc_o     (trunc_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          tr;   // checksum word of a truncated frame
        logic          cs;   // checksum word
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] fb[$];
    int            n_pass = 0;
    int            n_total = 0;
    int            n_wr = 0;
    int            cyc = 0;
    int            csum_cyc = 0;
    logic          prev_tr = 1'b0;
    logic          rand_full = 1'b0;
    logic [DW-1:0] exp_seq = '0;
    logic [15:0]   exp_frames = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Random FIFO back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_full) fifo_full = ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: every FIFO write must match the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_tr = 1'b0;
                continue;
            end
            chk("trunc_o", {31'd0, trunc_o}, {31'd0, prev_tr});
            prev_tr = 1'b0;
            chk("wr_while_full", {31'd0, fifo_wr_en_o & fifo_full}, 32'd0);
            if (fifo_wr_en_o) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {24'd0, fifo_wdata_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("fifo_wdata", {24'd0, fifo_wdata_o}, {24'd0, e.d});
                    prev_tr = e.tr;
                    if (e.cs) csum_cyc = cyc;
                end
            end else begin
                chk("wdata_zero_when_idle", {24'd0, fifo_wdata_o}, 32'd0);
            end
        end
    end

    // Reference model: header, first min(N,MAX) words, XOR of those words.
    function automatic int model_frame();
        int            n;
        int            l;
        logic [DW-1:0] cs;
        exp_t          e;
        n  = fb.size();
        l  = (n > MAX) ? MAX : n;
        cs = '0;
        e = '{d: exp_seq, tr: 1'b0, cs: 1'b0};
        exp_q.push_back(e);
        for (int i = 0; i < l; i++) begin
            e = '{d: fb[i], tr: 1'b0, cs: 1'b0};
            exp_q.push_back(e);
            cs = cs ^ fb[i];
        end
        e = '{d: cs, tr: (n > MAX), cs: 1'b1};
        exp_q.push_back(e);
        exp_seq    = exp_seq + 8'd1;
        exp_frames = exp_frames + 16'd1;
        return l + 2;
    endfunction

    task automatic send_word(input logic [DW-1:0] d, input logic l);
        bit done = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (s_ready_o) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("ready_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_data  = $urandom;
        s_last  = $urandom;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (!busy_o) done = 1;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit gaps);
        int nexp;
        int wr0;
        nexp = model_frame();
        wr0  = n_wr;
        for (int i = 0; i < fb.size(); i++) begin
            send_word(fb[i], (i == fb.size() - 1));
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        chk("frame_writes", n_wr - wr0, nexp);
        chk("queue_drained", exp_q.size(), 0);
        chk("seq_o", {24'd0, seq_o}, {24'd0, exp_seq});
        chk("frame_cnt_o", {16'd0, frame_cnt_o}, {16'd0, exp_frames});
    endtask

    initial begin
        int c0;
        int wr0;
        exp_t e;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_seq", {24'd0, seq_o}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
        chk("rst_ready", {31'd0, s_ready_o}, 32'd0);
        chk("rst_wr_en", {31'd0, fifo_wr_en_o}, 32'd0);
        @(posedge clk);
        #1;

        // Unthrottled 3-word frame with latency check.
        fb = '{8'h11, 8'h22, 8'h33};
        c0 = cyc;
        send_frame(0);
        chk("csum_cycle", csum_cyc - c0, 5);

        // Back-to-back frames.
        fb = '{8'hA5};
        send_frame(0);
        fb = '{8'h0F, 8'hF0};
        send_frame(0);

        // Three-cycle full stall mid-payload of a 4-word frame.
        fb = '{8'h01, 8'h02, 8'h03, 8'h04};
        void'(model_frame());
        wr0 = n_wr;
        send_word(8'h01, 0);
        send_word(8'h02, 0);
        s_valid = 1'b1;
        s_data = 8'h03;
        s_last = 1'b0;
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", {31'd0, s_ready_o}, 32'd0);
            chk("stall_wr_en", {31'd0, fifo_wr_en_o}, 32'd0);
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        send_word(8'h03, 0);
        send_word(8'h04, 1);
        wait_idle();
        chk("stall_writes", n_wr - wr0, 6);
        chk("stall_frame_cnt", {16'd0, frame_cnt_o}, {16'd0, exp_frames});

        // Over-length frame is truncated; exact-length frame is not.
        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(0);
        fb = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_frame(0);

        // Reset in the middle of a payload.
        e = '{d: exp_seq, tr: 1'b0, cs: 1'b0};
        exp_q.push_back(e);
        e = '{d: 8'h77, tr: 1'b0, cs: 1'b0};
        exp_q.push_back(e);
        e = '{d: 8'h88, tr: 1'b0, cs: 1'b0};
        exp_q.push_back(e);
        send_word(8'h77, 0);
        send_word(8'h88, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_seq", {24'd0, seq_o}, 32'd0);
        chk("midrst_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
        chk("midrst_trunc", {31'd0, trunc_o}, 32'd0);
        chk("midrst_wr_en", {31'd0, fifo_wr_en_o}, 32'd0);
        chk("midrst_wdata", {24'd0, fifo_wdata_o}, 32'd0);
        chk("midrst_partial_written", exp_q.size(), 0);
        rst = 1'b0;
        exp_seq = '0;
        exp_frames = '0;
        @(posedge clk);
        #1;
        fb = '{8'h5A, 8'h3C};
        send_frame(0);

        // Random frames under random back-pressure.
        rand_full = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(1, 7);
            fb.delete();
            for (int i = 0; i < n; i++) fb.push_back(DW'($urandom));
            send_frame(1);
        end
        rand_full = 1'b0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
